// File: rtl/instruction_fetch.sv
// instruction_fetch: loadable program memory feeding the processador iin port.
// Each word is held on iin for HOLD_CYCLES clocks. The walk stops on HALT_WORD
// or after the last address has been issued.
//
//   state | meaning
//   IDLE  | waiting for start; program memory writable
//   ISSUE | instruction on iin, hold counter running; memory read-only
//   DONE  | halt word reached or memory end passed; writable, restartable
module instruction_fetch #(
  parameter int                DATA_W      = 16,
  parameter int                ADDR_W      = 5,
  parameter int                HOLD_CYCLES = 4,
  parameter logic [DATA_W-1:0] HALT_WORD   = 16'hFFFF
) (
  input  logic              clock,
  input  logic              resetn,
  input  logic              load_en,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [DATA_W-1:0] load_data,
  input  logic              start,
  input  logic              stop,
  output logic [DATA_W-1:0] iin,
  output logic [ADDR_W-1:0] pc,
  output logic              issue,
  output logic              running,
  output logic              done
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int               DEPTH     = 1 << ADDR_W;
  localparam logic [7:0]        CNT_LAST  = 8'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;

  state_t            state;
  logic [7:0]        cnt;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0] pc_next;
  logic [DATA_W-1:0] word_first;
  logic [DATA_W-1:0] word_next;
  logic              end_of_prog;
  logic              write_ok;

  // Read ports: first word for start, following word for the end of a hold window.
  always_comb begin
    pc_next     = pc + ADDR_W'(1);
    word_first  = mem[0];
    word_next   = mem[pc_next];
    end_of_prog = (pc == LAST_ADDR) || (word_next == HALT_WORD);
    write_ok    = load_en && (state != ISSUE);
  end

  // Program memory write; contents deliberately survive reset so a program can be rerun.
  always_ff @(posedge clock) begin
    if (write_ok) begin
      mem[load_addr] <= load_data;
    end
  end

  // Sequencer FSM with registered outputs; issue defaults low and pulses on each new word.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state   <= IDLE;
      iin     <= '0;
      pc      <= '0;
      cnt     <= '0;
      issue   <= 1'b0;
      running <= 1'b0;
      done    <= 1'b0;
    end else begin
      issue <= 1'b0;
      case (state)
        IDLE, DONE: begin
          // A write in the same cycle as start wins; start must be repeated.
          if (start && !load_en) begin
            if (word_first != HALT_WORD) begin
              state   <= ISSUE;
              iin     <= word_first;
              pc      <= '0;
              cnt     <= '0;
              issue   <= 1'b1;
              running <= 1'b1;
              done    <= 1'b0;
            end else begin
              state   <= DONE;
              iin     <= '0;
              running <= 1'b0;
              done    <= 1'b1;
            end
          end
        end
        ISSUE: begin
          if (stop) begin
            state   <= IDLE;
            iin     <= '0;
            pc      <= '0;
            cnt     <= '0;
            running <= 1'b0;
            done    <= 1'b0;
          end else if (cnt == CNT_LAST) begin
            cnt <= '0;
            if (end_of_prog) begin
              state   <= DONE;
              iin     <= '0;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              iin   <= word_next;
              pc    <= pc_next;
              issue <= 1'b1;
            end
          end else begin
            cnt <= cnt + 8'd1;
          end
        end
        default: begin
          state   <= IDLE;
          iin     <= '0;
          pc      <= '0;
          cnt     <= '0;
          running <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: one instance with a 4-cycle hold and one with a 1-cycle hold.
module tb_instruction_fetch;

  logic        clock = 1'b0;
  logic        resetn = 1'b0;
  logic        load_en4 = 1'b0;
  logic        load_en1 = 1'b0;
  logic [4:0]  load_addr = '0;
  logic [15:0] load_data = '0;
  logic        start4 = 1'b0;
  logic        start1 = 1'b0;
  logic        stop4 = 1'b0;
  logic        stop1 = 1'b0;

  logic [15:0] iin4, iin1;
  logic [4:0]  pc4, pc1;
  logic        issue4, issue1, running4, running1, done4, done1;

  int checks = 0;
  int errors = 0;

  instruction_fetch #(.DATA_W(16), .ADDR_W(5), .HOLD_CYCLES(4), .HALT_WORD(16'hFFFF)) dut4 (
    .clock(clock), .resetn(resetn), .load_en(load_en4), .load_addr(load_addr),
    .load_data(load_data), .start(start4), .stop(stop4), .iin(iin4), .pc(pc4),
    .issue(issue4), .running(running4), .done(done4)
  );

  instruction_fetch #(.DATA_W(16), .ADDR_W(5), .HOLD_CYCLES(1), .HALT_WORD(16'hFFFF)) dut1 (
    .clock(clock), .resetn(resetn), .load_en(load_en1), .load_addr(load_addr),
    .load_data(load_data), .start(start1), .stop(stop1), .iin(iin1), .pc(pc1),
    .issue(issue1), .running(running1), .done(done1)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        start;
    logic [15:0] iin;
    logic [4:0]  pc;
    logic        issue;
    logic        running;
    logic        done;
  } vec_t;

  vec_t tab[$];

  function automatic logic [31:0] pack(logic [15:0] i, logic [4:0] p, logic is, logic r, logic d);
    return {8'h00, i, p, is, r, d};
  endfunction

  function automatic logic [31:0] snap4();
    return pack(iin4, pc4, issue4, running4, done4);
  endfunction

  function automatic logic [31:0] snap1();
    return pack(iin1, pc1, issue1, running1, done1);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] actual=%h required=%h (iin,pc,issue,running,done)", name, idx, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load_word(input logic [4:0] a, input logic [15:0] d, input logic e4, input logic e1);
    load_addr = a;
    load_data = d;
    load_en4  = e4;
    load_en1  = e1;
    tick();
    load_en4  = 1'b0;
    load_en1  = 1'b0;
  endtask

  task automatic build_table(input int h);
    logic [15:0] prog [4];
    prog[0] = 16'hA001; prog[1] = 16'hA400; prog[2] = 16'h4400; prog[3] = 16'h8400;
    tab.delete();
    for (int w = 0; w < 4; w++) begin
      for (int c = 0; c < h; c++) begin
        tab.push_back('{start: (w == 0 && c == 0), iin: prog[w], pc: 5'(w),
                        issue: (c == 0), running: 1'b1, done: 1'b0});
      end
    end
    tab.push_back('{start: 1'b0, iin: 16'h0000, pc: 5'd3, issue: 1'b0, running: 1'b0, done: 1'b1});
  endtask

  task automatic wait_done4(input string name, input int budget);
    int n;
    n = 0;
    while (!done4 && n < budget) begin
      tick();
      n++;
    end
    chk(name, n, {31'd0, done4}, 32'd1);
  endtask

  initial begin
    logic [15:0] prog [5];
    logic        seen;
    prog[0] = 16'hA001; prog[1] = 16'hA400; prog[2] = 16'h4400;
    prog[3] = 16'h8400; prog[4] = 16'hFFFF;

    // Reset state
    #12;
    chk("reset4", 0, snap4(), 32'd0);
    chk("reset1", 0, snap1(), 32'd0);
    resetn = 1'b1;
    tick();

    // Basic program loaded into both instances
    for (int a = 0; a < 5; a++) load_word(5'(a), prog[a], 1'b1, 1'b1);

    build_table(4);
    for (int i = 0; i < tab.size(); i++) begin
      start4 = tab[i].start;
      tick();
      chk("basic_h4", i, snap4(), pack(tab[i].iin, tab[i].pc, tab[i].issue, tab[i].running, tab[i].done));
    end
    start4 = 1'b0;
    chk("h1_idle_meanwhile", 0, snap1(), 32'd0);

    build_table(1);
    for (int i = 0; i < tab.size(); i++) begin
      start1 = tab[i].start;
      tick();
      chk("basic_h1", i, snap1(), pack(tab[i].iin, tab[i].pc, tab[i].issue, tab[i].running, tab[i].done));
    end
    start1 = 1'b0;

    // Stop while 4400 is held with cnt=2
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    for (int k = 1; k <= 10; k++) tick();
    chk("stop_pre", 0, snap4(), pack(16'h4400, 5'd2, 1'b0, 1'b1, 1'b0));
    stop4 = 1'b1;
    tick();
    stop4 = 1'b0;
    chk("stop_idle", 0, snap4(), 32'd0);
    tick();
    chk("stop_idle", 1, snap4(), 32'd0);
    // start and stop together in IDLE: start wins
    start4 = 1'b1;
    stop4  = 1'b1;
    tick();
    start4 = 1'b0;
    stop4  = 1'b0;
    chk("restart", 0, snap4(), pack(16'hA001, 5'd0, 1'b1, 1'b1, 1'b0));
    wait_done4("restart_done", 40);

    // Write attempted while running is ignored
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    load_word(5'd2, 16'h1234, 1'b1, 1'b0);
    seen = 1'b0;
    for (int k = 0; k < 40 && !done4; k++) begin
      if (issue4 && pc4 == 5'd2) begin
        seen = 1'b1;
        chk("run_write_ignored", 0, {16'd0, iin4}, 32'h4400);
      end
      tick();
    end
    chk("run_pc2_seen", 0, {31'd0, seen}, 32'd1);
    chk("run_write_done", 0, {31'd0, done4}, 32'd1);

    // Same write in DONE, together with start: only the write happens
    load_addr = 5'd2;
    load_data = 16'h1234;
    load_en4  = 1'b1;
    start4    = 1'b1;
    tick();
    load_en4  = 1'b0;
    chk("load_beats_start", 0, {30'd0, running4, done4}, 32'd1);
    tick();
    start4 = 1'b0;
    chk("restart2", 0, snap4(), pack(16'hA001, 5'd0, 1'b1, 1'b1, 1'b0));
    for (int k = 1; k <= 8; k++) tick();
    chk("done_write_seen", 0, snap4(), pack(16'h1234, 5'd2, 1'b1, 1'b1, 1'b0));
    wait_done4("restart2_done", 40);

    // Full memory of non-halt words: DONE after 32*H edges, no wrap
    for (int a = 0; a < 32; a++) load_word(5'(a), 16'h1000 + 16'(a), 1'b1, 1'b1);
    start4 = 1'b1;
    start1 = 1'b1;
    tick();
    start4 = 1'b0;
    start1 = 1'b0;
    chk("wrap_h4", 0, snap4(), pack(16'h1000, 5'd0, 1'b1, 1'b1, 1'b0));
    chk("wrap_h1", 0, snap1(), pack(16'h1000, 5'd0, 1'b1, 1'b1, 1'b0));
    for (int k = 1; k <= 130; k++) begin
      tick();
      if (k < 32)
        chk("wrap_h1", k, snap1(), pack(16'h1000 + 16'(k), 5'(k), 1'b1, 1'b1, 1'b0));
      else if (k == 32 || k == 33)
        chk("wrap_h1_done", k, snap1(), pack(16'h0000, 5'd31, 1'b0, 1'b0, 1'b1));
      if (k < 128 && (k % 4) == 0)
        chk("wrap_h4", k, snap4(), pack(16'h1000 + 16'(k / 4), 5'(k / 4), 1'b1, 1'b1, 1'b0));
      else if (k == 127)
        chk("wrap_h4_last", k, snap4(), pack(16'h101F, 5'd31, 1'b0, 1'b1, 1'b0));
      else if (k >= 128)
        chk("wrap_h4_done", k, snap4(), pack(16'h0000, 5'd31, 1'b0, 1'b0, 1'b1));
    end

    // Asynchronous reset between edges while issuing
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("areset_pre", 0, {31'd0, issue4}, 32'd1);
    #2;
    resetn = 1'b0;
    #1;
    chk("areset_now", 0, snap4(), 32'd0);
    #3;
    resetn = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("areset_idle", k, snap4(), 32'd0);
    end

    // Halt word at address 0, written in IDLE and started on the next cycle
    load_word(5'd0, 16'hFFFF, 1'b1, 1'b0);
    start4 = 1'b1;
    tick();
    start4 = 1'b0;
    chk("halt0", 0, snap4(), pack(16'h0000, 5'd0, 1'b0, 1'b0, 1'b1));
    for (int k = 1; k <= 3; k++) begin
      tick();
      chk("halt0_no_issue", k, snap4(), pack(16'h0000, 5'd0, 1'b0, 1'b0, 1'b1));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
